// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: ALU memory op codes, FSM states, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional build macro used by the unit: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  // ALU operation codes (memory subset plus the arithmetic codes the LSU must ignore)
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;
  localparam logic [5:0] ALU_LB  = 6'd20;
  localparam logic [5:0] ALU_LH  = 6'd21;
  localparam logic [5:0] ALU_LW  = 6'd22;
  localparam logic [5:0] ALU_LBU = 6'd23;
  localparam logic [5:0] ALU_LHU = 6'd24;
  localparam logic [5:0] ALU_SB  = 6'd25;
  localparam logic [5:0] ALU_SH  = 6'd26;
  localparam logic [5:0] ALU_SW  = 6'd27;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
      ALU_SB, ALU_SH, ALU_SW: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
  endfunction

  // Timeout counter is at least 8 bits, wider only when the limit needs it
  function automatic int cnt_width(input int unsigned limit);
    return (limit > 255) ? $clog2(limit + 1) : 8;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store-data replication, load extraction/extension, misalign flag.
// Latency: purely combinational.
// Backpressure: none; the parent decides when the outputs are used.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [5:0]  alucode_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half lanes of the read word
  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Per-op enables, replicated store data and extended load data; sub-alignment bits are dropped
  always_comb begin
    be_o       = 4'h0;
    wdata_o    = wdata_i;
    ld_data_o  = rdata_i;
    misalign_o = 1'b0;
    case (alucode_i)
      ALU_LB, ALU_LBU, ALU_SB: begin
        be_o      = 4'b0001 << addr_i;
        wdata_o   = {4{wdata_i[7:0]}};
        ld_data_o = (alucode_i == ALU_LB) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      end
      ALU_LH, ALU_LHU, ALU_SH: begin
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        ld_data_o  = (alucode_i == ALU_LH) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        misalign_o = addr_i[0];
      end
      ALU_LW, ALU_SW: begin
        be_o       = 4'hF;
        misalign_o = |addr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one word-wide memory transaction per accepted request, aligned/extended load result.
// Latency: accept N, mem_req N+1, earliest rsp_valid N+2 (N+1 for a trapped misaligned access).
// Backpressure: req_ready only in IDLE; mem_req held until mem_ack or MEM_TIMEOUT. Macro: LSU_MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  alucode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_misalign
);

  localparam int             CW       = cnt_width(MEM_TIMEOUT);
  localparam logic [CW-1:0]  TO_LIMIT = CW'(MEM_TIMEOUT);
  localparam bit             TO_EN    = (MEM_TIMEOUT != 0);

  lsu_state_e     state_q;
  logic [5:0]     op_q;
  logic [1:0]     off_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           req_ready_q;
  logic           mem_req_q, mem_we_q;
  logic [31:0]    mem_addr_q, mem_wdata_q;
  logic [3:0]     mem_be_q;
  logic           rsp_valid_q, rsp_err_q, rsp_misalign_q;
  logic [31:0]    rsp_data_q;

  logic [5:0]     al_op;
  logic [1:0]     al_off;
  logic [3:0]     al_be;
  logic [31:0]    al_wdata, al_ld;
  logic           al_misalign;
  logic           accept;
  logic           trap;

  // In IDLE the steering sees the incoming request; afterwards it sees the latched op for load extraction
  assign al_op  = (state_q == LSU_IDLE) ? alucode    : op_q;
  assign al_off = (state_q == LSU_IDLE) ? addr[1:0]  : off_q;

  lsu_align u_align (
    .alucode_i  (al_op),
    .addr_i     (al_off),
    .wdata_i    (wdata),
    .rdata_i    (mem_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .ld_data_o  (al_ld),
    .misalign_o (al_misalign)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = al_misalign;
`else
  // Misaligned accesses proceed with the low address bits ignored
  assign trap = al_misalign & 1'b0;
`endif

  assign accept = req_valid & req_ready_q & is_mem_op(alucode);
  assign cnt_d  = cnt_q + CW'(1);

  // Request/response FSM with all memory-side and response outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= LSU_IDLE;
      op_q           <= '0;
      off_q          <= '0;
      cnt_q          <= '0;
      req_ready_q    <= 1'b1;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_be_q       <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      rsp_misalign_q <= 1'b0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (accept) begin
            op_q        <= alucode;
            off_q       <= addr[1:0];
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            if (trap) begin
              // Refused without touching memory; response follows immediately
              state_q        <= LSU_RESP;
              rsp_valid_q    <= 1'b1;
              rsp_misalign_q <= 1'b1;
              rsp_data_q     <= '0;
            end else begin
              state_q     <= LSU_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store_op(alucode);
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_be_q    <= al_be;
              mem_wdata_q <= al_wdata;
            end
          end
        end
        LSU_REQ: begin
          if (mem_ack) begin
            // Ack wins over a timeout landing in the same cycle
            state_q     <= LSU_RESP;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= mem_we_q ? 32'h0 : al_ld;
          end else if (TO_EN && (cnt_d == TO_LIMIT)) begin
            state_q     <= LSU_RESP;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        LSU_RESP: begin
          state_q        <= LSU_IDLE;
          req_ready_q    <= 1'b1;
          rsp_valid_q    <= 1'b0;
          rsp_err_q      <= 1'b0;
          rsp_misalign_q <= 1'b0;
          rsp_data_q     <= '0;
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_be       = mem_be_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_misalign = rsp_misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed plan items plus random transactions against a lane-arithmetic model.
// Inputs change and outputs are sampled on the falling clock edge.
// Honors LSU_MISALIGN_TRAP_EN the same way the design build does.
module tb_lsu;
  import lsu_pkg::*;

  localparam int TO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  alucode = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid, rsp_err, rsp_misalign;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rsp;
  logic [31:0] last_wd;
  logic [3:0]  last_be;

  lsu #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .alucode(alucode), .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_misalign(rsp_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access size in bytes and lane arithmetic ----
  function automatic int op_size(input logic [5:0] op);
    if (op == ALU_LB || op == ALU_LBU || op == ALU_SB) return 1;
    if (op == ALU_LH || op == ALU_LHU || op == ALU_SH) return 2;
    if (op == ALU_LW || op == ALU_SW) return 4;
    return 0;
  endfunction

  function automatic int lane_off(input int sz, input logic [31:0] a);
    int o;
    o = int'(a % 4);
    return o - (o % sz);
  endfunction

  function automatic logic [3:0] model_be(input int sz, input int off);
    int m;
    m = ((1 << sz) - 1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] wd);
    longint unsigned mask, res;
    mask = (64'd1 << (8 * sz)) - 1;
    res = 0;
    for (int i = 0; i < 4 / sz; i++) res = res | ((longint'(wd) & mask) << (8 * sz * i));
    return res[31:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input int sz, input int off,
                                             input logic [31:0] rd);
    longint v;
    longint unsigned u;
    if (sz == 4) return rd;
    u = (longint'(rd) >> (8 * off)) & ((64'd1 << (8 * sz)) - 1);
    v = longint'(u);
    if ((op == ALU_LB || op == ALU_LH) && u >= (64'd1 << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  // One request from the execute stage; ack_dly = REQ-cycle index carrying mem_ack, negative = never
  task automatic run_txn(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int ack_dly);
    int sz, off, n_req;
    bit mis, trap, st, exp_err;
    logic [31:0] exp_rsp;
    sz = op_size(op);
    chk({tag, ".ready_idle"}, req_ready, 1);
    req_valid = 1'b1; alucode = op; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; wdata = $urandom; addr = $urandom;
    if (sz == 0) begin
      for (int i = 0; i < 2; i++) begin
        chk({tag, ".nonmem_req"}, mem_req, 0);
        chk({tag, ".nonmem_ready"}, req_ready, 1);
        chk({tag, ".nonmem_rsp"}, rsp_valid, 0);
        @(negedge clk);
      end
      return;
    end
    off  = lane_off(sz, a);
    mis  = (a % sz) != 0;
    trap = mis && TRAP;
    st   = (op == ALU_SB || op == ALU_SH || op == ALU_SW);
    exp_err = !trap && (ack_dly < 0 || ack_dly >= TO);
    n_req = trap ? 0 : (exp_err ? TO : ack_dly + 1);
    exp_rsp = (st || exp_err || trap) ? 32'h0 : model_load(op, sz, off, rd);
    for (int c = 0; c < n_req; c++) begin
      chk({tag, ".mem_req"}, mem_req, 1);
      chk({tag, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
      chk({tag, ".mem_be"}, mem_be, model_be(sz, off));
      chk({tag, ".mem_we"}, mem_we, st);
      if (st) chk({tag, ".mem_wdata"}, mem_wdata, model_wdata(sz, wd));
      chk({tag, ".ready_busy"}, req_ready, 0);
      chk({tag, ".early_rsp"}, rsp_valid, 0);
      last_wd = mem_wdata; last_be = mem_be;
      if (c == ack_dly) begin mem_ack = 1'b1; mem_rdata = rd; end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    chk({tag, ".req_drop"}, mem_req, 0);
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
    chk({tag, ".rsp_err"}, rsp_err, exp_err);
    chk({tag, ".rsp_misalign"}, rsp_misalign, trap);
    chk({tag, ".rsp_data"}, rsp_data, exp_rsp);
    last_rsp = rsp_data;
    @(negedge clk);
    chk({tag, ".rsp_once"}, rsp_valid, 0);
    chk({tag, ".ready_back"}, req_ready, 1);
  endtask

  initial begin : main
    logic [5:0] ops [9];
    logic [5:0] op;
    ops = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW, ALU_ADD};

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.req_ready", req_ready, 1);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.mem_be", mem_be, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_data", rsp_data, 0);
    chk("rst.rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. SW with ack in the first REQ cycle
    run_txn("sw", ALU_SW, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    chk("sw.wdata_lit", last_wd, 32'hDEADBEEF);

    // 2. Sub-word loads
    run_txn("lb", ALU_LB, 32'h103, 32'h0, 32'h80FF7F01, 0);
    chk("lb.lit", last_rsp, 32'hFFFFFF80);
    chk("lb.be_lit", {28'h0, last_be}, 32'h8);
    run_txn("lbu", ALU_LBU, 32'h103, 32'h0, 32'h80FF7F01, 0);
    chk("lbu.lit", last_rsp, 32'h00000080);
    run_txn("lh", ALU_LH, 32'h102, 32'h0, 32'h80FF7F01, 0);
    chk("lh.lit", last_rsp, 32'hFFFF80FF);
    run_txn("lhu", ALU_LHU, 32'h102, 32'h0, 32'h80FF7F01, 0);
    chk("lhu.lit", last_rsp, 32'h000080FF);

    // 3. Sub-word stores
    run_txn("sb", ALU_SB, 32'h101, 32'h123456AB, 32'h0, 0);
    chk("sb.wdata_lit", last_wd, 32'hABABABAB);
    chk("sb.be_lit", {28'h0, last_be}, 32'h2);
    run_txn("sh", ALU_SH, 32'h102, 32'h0000CAFE, 32'h0, 0);
    chk("sh.wdata_lit", last_wd, 32'hCAFECAFE);
    chk("sh.be_lit", {28'h0, last_be}, 32'hC);

    // 4. Delayed ack, timeout, ack exactly at the limit
    run_txn("lw_dly2", ALU_LW, 32'h2000, 32'h0, 32'hA5A5_0F0F, 2);
    run_txn("lw_at_limit", ALU_LW, 32'h2004, 32'h0, 32'h1357_9BDF, TO - 1);
    chk("lw_at_limit.lit", last_rsp, 32'h13579BDF);
    run_txn("lw_timeout", ALU_LW, 32'h2008, 32'h0, 32'h0, -1);

    // 5. Misaligned word load
    run_txn("lw_mis", ALU_LW, 32'h102, 32'h0, 32'h11223344, 0);
    chk("lw_mis.lit", last_rsp, TRAP ? 32'h0 : 32'h11223344);

    // 6. Non-memory op, then reset while a request is outstanding
    run_txn("add", ALU_ADD, 32'h100, 32'h1, 32'h0, 0);
    req_valid = 1'b1; alucode = ALU_LW; addr = 32'h300;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstreq.mem_req_before", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstreq.mem_req", mem_req, 0);
    chk("rstreq.req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstreq.no_rsp", rsp_valid, 0);
      chk("rstreq.no_req", mem_req, 0);
    end

    // Random transactions
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 8)];
      run_txn("rand", op, $urandom, $urandom, $urandom, int'($urandom_range(0, 5)) - (i % 7 == 0 ? 10 : 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
